// File: rtl/risc_io_pkg.sv
// Shared definitions for the risc_io block: register map, status bits, UART FSM states.
// No logic; latency n/a.
// Backpressure n/a.
package risc_io_pkg;

    localparam int CLK_PER_MS_DEF = 25000;
    localparam int BAUD_DIV_DEF   = 217;

    localparam logic [3:0] REG_MS   = 4'd0;
    localparam logic [3:0] REG_IO   = 4'd1;
    localparam logic [3:0] REG_UART = 4'd2;
    localparam logic [3:0] REG_STAT = 4'd3;

    localparam int STAT_RXRDY = 0;
    localparam int STAT_TXRDY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_st_t;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch and framing rejection.
// Latency: done pulses one cycle after the stop-bit sample; data holds the last good byte.
// Backpressure: none; a new byte simply replaces data.
module uart_rx
    import risc_io_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       done
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);

    logic          sync1, sync2, prev;
    uart_st_t      st;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            st    <= ST_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            sh    <= '0;
            data  <= '0;
            done  <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            prev  <= sync2;
            done  <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (prev && !sync2) begin
                        st  <= ST_START;
                        cnt <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that is high again at its midpoint was only a glitch.
                    if (cnt == HALF_END) begin
                        cnt  <= '0;
                        bitn <= '0;
                        st   <= sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt  <= '0;
                        sh   <= {sync2, sh[7:1]};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7)
                            st <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        st  <= ST_IDLE;
                        if (sync2) begin
                            data <= sh;
                            done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/risc_io.sv
// CPU I/O block: ms timer, switches/LEDs, UART TX and RX with ready flags, combinational read mux.
// Latency: reads combinational; writes and read side effects take effect at the next edge.
// Backpressure: TX writes are dropped while the transmitter is busy; RX overruns overwrite.
module risc_io
    import risc_io_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int BAUD_DIV   = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ioadr,
    input  logic        iord,
    input  logic        iowr,
    input  logic [31:0] outbus,
    output logic [31:0] inbus,
    input  logic [7:0]  swi,
    output logic [7:0]  leds,
    input  logic        RxD,
    output logic        TxD
);

    localparam int PW = $clog2(CLK_PER_MS + 1);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [PW-1:0] PRESC_END = PW'(CLK_PER_MS - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(BAUD_DIV - 1);

    logic [3:0]    sel;
    logic          rd_phase, rd_fire;
    logic [PW-1:0] presc;
    logic [31:0]   ms_cnt;
    logic [7:0]    rxdata;
    logic          rx_done, rxrdy, txrdy;
    uart_st_t      tx_st;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_last, tx_load;
    logic          unused_bits;

    assign sel         = ioadr[5:2];
    assign rd_fire     = iord & rd_phase;
    assign unused_bits = ^{ioadr[1:0], outbus[31:8]};

    // The last stop-bit cycle also accepts a write so frames can run back to back.
    assign tx_last = (tx_st == ST_STOP) && (tx_cnt == BIT_END);
    assign tx_load = iowr && (sel == REG_UART) && (txrdy || tx_last);

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
        .clk  (clk),
        .rst  (rst),
        .rxd  (RxD),
        .data (rxdata),
        .done (rx_done)
    );

    always_comb begin
        inbus = '0;
        if (iord) begin
            case (sel)
                REG_MS:   inbus = ms_cnt;
                REG_IO:   inbus = {24'b0, swi};
                REG_UART: inbus = {24'b0, rxdata};
                REG_STAT: begin
                    inbus[STAT_RXRDY] = rxrdy;
                    inbus[STAT_TXRDY] = txrdy;
                end
                default:  inbus = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc == PRESC_END) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 32'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Loads hold iord for two cycles; side effects act on the second one only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_phase <= 1'b0;
            leds     <= '0;
            rxrdy    <= 1'b0;
        end else begin
            rd_phase <= iord ? ~rd_phase : 1'b0;
            if (iowr && sel == REG_IO)
                leds <= outbus[7:0];
            if (rx_done)
                rxrdy <= 1'b1;
            else if (rd_fire && sel == REG_UART)
                rxrdy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st  <= ST_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            TxD    <= 1'b1;
            txrdy  <= 1'b1;
        end else begin
            case (tx_st)
                ST_IDLE: ;
                ST_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        tx_bit <= '0;
                        TxD    <= tx_sh[0];
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_st  <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            TxD   <= 1'b1;
                            tx_st <= ST_STOP;
                        end else begin
                            TxD    <= tx_sh[0];
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        txrdy  <= 1'b1;
                        tx_st  <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_st <= ST_IDLE;
            endcase
            if (tx_load) begin
                tx_sh  <= outbus[7:0];
                tx_cnt <= '0;
                TxD    <= 1'b0;
                txrdy  <= 1'b0;
                tx_st  <= ST_START;
            end
        end
    end

endmodule

// File: doc/risc_io.md
RISC_IO -- requirements
Module: risc_io

Interface
REQ-001 Parameter CLK_PER_MS, default 25000: clk cycles per millisecond tick.
REQ-002 Parameter BAUD_DIV, default 217: clk cycles per UART bit (25 MHz / 115200).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ioadr  input  6  CPU I/O byte address; ioadr[1:0] ignored; register select = ioadr[5:2].
REQ-006 iord  input  1  CPU I/O read strobe; held 2 cycles per load instruction.
REQ-007 iowr  input  1  CPU I/O write strobe; one write per high cycle.
REQ-008 outbus  input  32  CPU write data.
REQ-009 inbus  output  32  read data to CPU; combinational from ioadr and registered state.
REQ-010 swi  input  8  board switches.
REQ-011 leds  output  8  board LEDs.
REQ-012 RxD  input  1  UART serial in, asynchronous, idle high.
REQ-013 TxD  output  1  UART serial out, idle high.

Function
REQ-014 Register map (ioadr[5:2]): 0 ms counter (R); 1 R = {24'b0, swi}, W leds <= outbus[7:0]; 2 R = {24'b0, rxdata}, W starts TX of outbus[7:0]; 3 R = {30'b0, txrdy, rxrdy}, W ignored; 4..15 read 0, writes ignored.
REQ-015 inbus shall be valid in every cycle iord is high, independent of the previous cycle; inbus shall be 0 when iord is low.
REQ-016 Prescaler counts 0..CLK_PER_MS-1; on wrap the 32-bit ms counter increments; 32'hFFFFFFFF wraps to 0.
REQ-017 Read phase flag: set on the first iord-high cycle, toggled on each further iord-high cycle, cleared when iord is low; read side effects fire only on phase=1 cycles, i.e. once per load, including back-to-back loads.
REQ-018 A phase=1 read of register 2 clears rxrdy at the next edge; the data returned in that cycle is the pre-clear rxdata.
REQ-019 TX: write to register 2 while txrdy=1 loads the byte and clears txrdy; writes while txrdy=0 are ignored.
REQ-020 TX frame 8N1: start bit 0, data LSB first, stop bit 1; each bit exactly BAUD_DIV cycles; TxD start bit begins the cycle after the write.
REQ-021 txrdy returns to 1 at the end of the stop bit; a new write is accepted in that same cycle.
REQ-022 RX: RxD passes through a 2-flop synchronizer; a synchronized falling edge in IDLE starts a frame.
REQ-023 RX samples at BAUD_DIV/2 into the start bit; if the sample is 1, abort to IDLE (glitch); then sample each data bit and the stop bit at BAUD_DIV intervals.
REQ-024 RX stop bit 1: rxdata <= byte, rxrdy <= 1; stop bit 0: byte discarded, rxrdy unchanged (framing error).
REQ-025 Overrun: a new byte overwrites rxdata and rxrdy stays 1.
REQ-026 Simultaneous byte completion and rxrdy-clearing read: set wins; rxrdy = 1.
REQ-027 RX and TX state machines: IDLE, START, DATA (3-bit bit counter), STOP.

Reset
REQ-028 rst low: leds = 0, TxD = 1, txrdy = 1, rxrdy = 0, rxdata = 0, ms counter and prescaler = 0, both FSMs IDLE, synchronizer flops = 1, read phase = 0.
REQ-029 Reset mid-frame aborts the frame; TxD returns high immediately (asynchronously).

Structure
REQ-030 Shared package: register index constants (0..3), status bit positions, FSM state encoding, parameter defaults.
REQ-031 One sub-module, uart_rx (synchronizer, RX FSM, rxdata, done pulse); TX, timer, decode and rxrdy flag live in risc_io.

Verification (CLK_PER_MS = 10, BAUD_DIV = 8)
REQ-032 Reset, run 35 cycles, read register 0 -> inbus = 3; status read -> 32'h2.
REQ-033 Write 32'h1A5 to register 1 -> leds = 8'hA5; swi = 8'h3C, read register 1 -> inbus = 32'h3C.
REQ-034 Write 8'h53 to register 2 -> TxD sequence 0,1,1,0,0,1,0,1,0,1, each bit 8 cycles; txrdy low for 80 cycles; a second write mid-frame is ignored.
REQ-035 Drive RxD frame for 8'hC4 -> rxrdy = 1; 2-cycle read of register 2 -> inbus = 32'hC4 in both cycles, rxrdy = 0 afterwards; a 3-cycle low glitch on RxD -> no rxrdy.
REQ-036 RxD frame with stop bit 0 -> rxrdy stays 0; two frames without a read -> rxdata = second byte, rxrdy = 1.
REQ-037 Assert rst during the TX data bits -> TxD = 1 and txrdy = 1 immediately; after release, a new TX frame completes correctly.
